// File: rtl/apb_intc_hub.sv
// apb_intc_hub
//   APB interconnect plus a small interrupt controller. One CPU APB master is
//   decoded onto four external slaves (system, uart, timer, sram) or the
//   internal intc register window; unmapped addresses get an immediate error.
//   Timer interrupts and bus-error completions are collected into cpu_irq.
//
// Ports
//   clk, rts               clock, synchronous active-high reset
//   paddr/pwdata/pwrite/   master request (pstb = byte write strobes)
//   pstb/psel/penable
//   prdata/pready/perr     master response
//   <s>_sel/<s>_enable     routed select/enable per external slave
//   <s>_rdata/_ready/_err  external slave response
//   timer_irq              level interrupt from the timer
//   cpu_irq                level interrupt to the CPU
//
// Register layout assumes 32-bit address and data.
module apb_intc_hub #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rts,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pwrite,
  input  logic [3:0]            pstb,
  input  logic                  psel,
  input  logic                  penable,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  perr,
  output logic                  system_sel,
  output logic                  system_enable,
  input  logic [DATA_WIDTH-1:0] system_rdata,
  input  logic                  system_ready,
  input  logic                  system_err,
  output logic                  uart_sel,
  output logic                  uart_enable,
  input  logic [DATA_WIDTH-1:0] uart_rdata,
  input  logic                  uart_ready,
  input  logic                  uart_err,
  output logic                  timer_sel,
  output logic                  timer_enable,
  input  logic [DATA_WIDTH-1:0] timer_rdata,
  input  logic                  timer_ready,
  input  logic                  timer_err,
  output logic                  sram_sel,
  output logic                  sram_enable,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  input  logic                  sram_ready,
  input  logic                  sram_err,
  input  logic                  timer_irq,
  output logic                  cpu_irq
);

  localparam logic [19:0] UART_PG  = 20'h10000;
  localparam logic [19:0] INTC_PG  = 20'h10001;
  localparam logic [19:0] TIMER_PG = 20'h10002;

  logic [1:0] r_pend;
  logic [1:0] r_en;
  logic       r_gen;

  logic w_hit_sys, w_hit_uart, w_hit_intc, w_hit_timer, w_hit_sram;
  logic [9:0] w_word;
  logic       w_off_ok;
  logic       w_intc_acc;
  logic       w_wr;
  logic [1:0] w_clr;
  logic [1:0] w_set;
  logic [1:0] w_act;
  logic [DATA_WIDTH-1:0] w_intc_rdata;
  logic       w_unused;

  // Priority decode; regions are disjoint, but the order is kept explicit.
  always_comb begin
    w_hit_sys   = 1'b0;
    w_hit_uart  = 1'b0;
    w_hit_intc  = 1'b0;
    w_hit_timer = 1'b0;
    w_hit_sram  = 1'b0;
    if (paddr[31])                     w_hit_sram  = 1'b1;
    else if (paddr[31:16] == 16'h0000) w_hit_sys   = 1'b1;
    else if (paddr[31:12] == UART_PG)  w_hit_uart  = 1'b1;
    else if (paddr[31:12] == INTC_PG)  w_hit_intc  = 1'b1;
    else if (paddr[31:12] == TIMER_PG) w_hit_timer = 1'b1;
  end

  assign system_sel    = psel    & w_hit_sys;
  assign system_enable = penable & w_hit_sys;
  assign uart_sel      = psel    & w_hit_uart;
  assign uart_enable   = penable & w_hit_uart;
  assign timer_sel     = psel    & w_hit_timer;
  assign timer_enable  = penable & w_hit_timer;
  assign sram_sel      = psel    & w_hit_sram;
  assign sram_enable   = penable & w_hit_sram;

  // intc window: only word offsets 0, 4 and 8 exist.
  assign w_word     = paddr[11:2];
  assign w_off_ok   = (paddr[1:0] == 2'b00) && (w_word < 10'd3);
  assign w_intc_acc = psel & penable & w_hit_intc;
  assign w_wr       = w_intc_acc & pwrite & w_off_ok & ~rts;
  assign w_act      = r_pend & r_en;

  always_comb begin
    w_intc_rdata = '0;
    if (!rts && w_off_ok) begin
      case (w_word)
        10'd0: w_intc_rdata[1:0] = r_pend;
        10'd1: begin
          w_intc_rdata[1:0] = r_en;
          w_intc_rdata[31]  = r_gen;
        end
        default: begin
          // CAUSE: lowest pending&enabled source, all-ones when none.
          if (w_act[0])      w_intc_rdata = '0;
          else if (w_act[1]) w_intc_rdata = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
          else               w_intc_rdata = '1;
        end
      endcase
    end
  end

  // Response mux. prdata follows the decoded slave even outside psel;
  // handshake outputs are gated by psel.
  always_comb begin
    prdata = '0;
    pready = 1'b0;
    perr   = 1'b0;
    if (w_hit_sram) begin
      prdata = sram_rdata;
      pready = psel & sram_ready;
      perr   = psel & sram_err;
    end else if (w_hit_sys) begin
      prdata = system_rdata;
      pready = psel & system_ready;
      perr   = psel & system_err;
    end else if (w_hit_uart) begin
      prdata = uart_rdata;
      pready = psel & uart_ready;
      perr   = psel & uart_err;
    end else if (w_hit_intc) begin
      prdata = w_intc_rdata;
      pready = psel & penable;
      perr   = psel & penable & ~w_off_ok;
    end else if (w_hit_timer) begin
      prdata = timer_rdata;
      pready = psel & timer_ready;
      perr   = psel & timer_err;
    end else begin
      pready = psel & penable;
      perr   = psel & penable;
    end
  end

  // Sets take priority over write-1-clear on the same bit.
  assign w_set = {psel & penable & pready & perr, timer_irq};
  assign w_clr = (w_wr && w_word == 10'd0 && pstb[0]) ? pwdata[1:0] : 2'b00;

  always_ff @(posedge clk) begin
    if (rts) begin
      r_pend <= 2'b00;
      r_en   <= 2'b00;
      r_gen  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
      if (w_wr && w_word == 10'd1) begin
        if (pstb[0]) r_en  <= pwdata[1:0];
        if (pstb[3]) r_gen <= pwdata[31];
      end
    end
  end

  assign cpu_irq = r_gen & |w_act;

  assign w_unused = &{1'b0, pwdata[DATA_WIDTH-2:2], pstb[2:1]};

endmodule

// File: tb/tb_apb_intc_hub.sv
module tb_apb_intc_hub;
  logic        clk = 1'b0;
  logic        rts;
  logic [31:0] paddr, pwdata;
  logic        pwrite;
  logic [3:0]  pstb;
  logic        psel, penable;
  logic [31:0] prdata;
  logic        pready, perr, cpu_irq;
  logic        timer_irq;
  // slave index: 0 system, 1 uart, 2 timer, 3 sram
  logic [31:0] s_rdata [4];
  logic [3:0]  s_ready, s_err, s_sel, s_en;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [1:0]  m_pend;
  logic [31:0] m_en;

  logic [31:0] last_rdata;
  logic        last_rdy, last_err;
  logic [3:0]  last_sel;

  always #5 clk = ~clk;

  apb_intc_hub dut (
    .clk(clk), .rts(rts), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .pstb(pstb), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .perr(perr),
    .system_sel(s_sel[0]), .system_enable(s_en[0]), .system_rdata(s_rdata[0]),
    .system_ready(s_ready[0]), .system_err(s_err[0]),
    .uart_sel(s_sel[1]), .uart_enable(s_en[1]), .uart_rdata(s_rdata[1]),
    .uart_ready(s_ready[1]), .uart_err(s_err[1]),
    .timer_sel(s_sel[2]), .timer_enable(s_en[2]), .timer_rdata(s_rdata[2]),
    .timer_ready(s_ready[2]), .timer_err(s_err[2]),
    .sram_sel(s_sel[3]), .sram_enable(s_en[3]), .sram_rdata(s_rdata[3]),
    .sram_ready(s_ready[3]), .sram_err(s_err[3]),
    .timer_irq(timer_irq), .cpu_irq(cpu_irq)
  );

  // 0..3 external slaves, 4 intc, 5 unmapped
  function automatic int region(input logic [31:0] a);
    if (a >= 32'h8000_0000) return 3;
    if (a <= 32'h0000_FFFF) return 0;
    if (a >= 32'h1000_0000 && a <= 32'h1000_0FFF) return 1;
    if (a >= 32'h1000_1000 && a <= 32'h1000_1FFF) return 4;
    if (a >= 32'h1000_2000 && a <= 32'h1000_2FFF) return 2;
    return 5;
  endfunction

  function automatic bit intc_bad(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h1000_1000;
    return !(off == 0 || off == 4 || off == 8);
  endfunction

  function automatic logic [31:0] intc_read(input logic [31:0] a);
    logic [31:0] off;
    logic [1:0]  pe;
    off = a - 32'h1000_1000;
    pe  = m_pend & m_en[1:0];
    if (rts) return 32'h0;
    case (off)
      32'h0: return {30'h0, m_pend};
      32'h4: return m_en;
      32'h8: return pe[0] ? 32'h0 : (pe[1] ? 32'h1 : 32'hFFFF_FFFF);
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s: got %h expected %h", tag, what, obs, exp);
    end
  endtask

  // One clock: check combinational outputs against the model mid-cycle,
  // then advance the model across the rising edge.
  task automatic step(input string tag);
    int r;
    logic [3:0]  e_sel, e_en;
    logic        e_rdy, e_err, e_irq, be;
    logic [31:0] e_rd, off;
    logic [1:0]  clr;
    @(negedge clk);
    r = region(paddr);
    e_sel = 4'h0; e_en = 4'h0;
    e_rdy = 1'b0; e_err = 1'b0; e_rd = 32'h0;
    if (r < 4) begin
      e_sel[r] = psel;
      e_en[r]  = penable;
      e_rd     = s_rdata[r];
      e_rdy    = psel & s_ready[r];
      e_err    = psel & s_err[r];
    end else if (r == 4) begin
      e_rd  = intc_read(paddr);
      e_rdy = psel & penable;
      e_err = psel & penable & intc_bad(paddr);
    end else begin
      e_rdy = psel & penable;
      e_err = psel & penable;
    end
    e_irq = m_en[31] & |(m_pend & m_en[1:0]);
    chk(tag, "sel_en", {24'h0, s_sel, s_en}, {24'h0, e_sel, e_en});
    chk(tag, "pready", {31'h0, pready}, {31'h0, e_rdy});
    chk(tag, "perr", {31'h0, perr}, {31'h0, e_err});
    chk(tag, "prdata", prdata, e_rd);
    chk(tag, "cpu_irq", {31'h0, cpu_irq}, {31'h0, e_irq});
    last_rdata = prdata; last_rdy = pready; last_err = perr; last_sel = s_sel;
    be = psel & penable & e_rdy & e_err;
    if (rts) begin
      m_pend = 2'b00;
      m_en   = 32'h0;
    end else begin
      clr = 2'b00;
      if (psel && penable && pwrite && r == 4 && !intc_bad(paddr)) begin
        off = paddr - 32'h1000_1000;
        if (off == 0 && pstb[0]) clr = pwdata[1:0];
        if (off == 4) begin
          if (pstb[0]) m_en[1:0] = pwdata[1:0];
          if (pstb[3]) m_en[31]  = pwdata[31];
        end
      end
      m_pend = (m_pend & ~clr) | {be, timer_irq};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [31:0] a, input bit wr, input logic [31:0] d,
                      input logic [3:0] st, input int waits, input bit serr,
                      output logic [31:0] rd);
    paddr = a; pwrite = wr; pwdata = d; pstb = st;
    psel = 1'b1; penable = 1'b0; s_ready = 4'h0; s_err = 4'h0;
    step("setup");
    penable = 1'b1;
    for (int i = 0; i < waits; i++) begin
      step("wait");
      if (region(a) < 4) chk("wait", "pready", {31'h0, last_rdy}, 32'h0);
    end
    s_ready = 4'hF;
    s_err   = serr ? 4'hF : 4'h0;
    step("access");
    rd = last_rdata;
    psel = 1'b0; penable = 1'b0; s_ready = 4'h0; s_err = 4'h0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    int sel, w;
    logic [31:0] offs [9];
    logic [31:0] umap [4];
    offs = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h6};
    umap = '{32'h2000_0000, 32'h1000_3000, 32'h0001_0000, 32'h7FFF_FFFC};

    rts = 1'b1; timer_irq = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; pstb = 4'h0;
    s_ready = 4'h0; s_err = 4'h0;
    for (int i = 0; i < 4; i++) s_rdata[i] = $urandom;
    m_pend = 2'b00; m_en = 32'h0;
    @(posedge clk); #1;

    // reset held with timer_irq=1; setup of the first read in the last reset cycle
    step("rst0");
    chk("rst0", "cpu_irq", {31'h0, cpu_irq}, 32'h0);
    paddr = 32'h1000_1000; pwrite = 1'b0; psel = 1'b1;
    step("rst1");
    chk("rst1", "cpu_irq", {31'h0, cpu_irq}, 32'h0);
    rts = 1'b0; penable = 1'b1;
    step("rd_after_rst");
    chk("rd_after_rst", "pending", last_rdata, 32'h0);
    psel = 1'b0; penable = 1'b0;
    xfer(32'h1000_1000, 0, 0, 4'h0, 0, 0, rd);
    chk("rd2_after_rst", "pending", rd, 32'h1);
    timer_irq = 1'b0;

    // decode and data mux
    xfer(32'h8000_0010, 0, 0, 4'h0, 0, 0, rd);
    chk("dec_sram", "sel", {28'h0, last_sel}, 32'h8);
    chk("dec_sram", "rdata", rd, s_rdata[3]);
    xfer(32'h0000_0004, 0, 0, 4'h0, 0, 0, rd);
    chk("dec_sys", "sel", {28'h0, last_sel}, 32'h1);
    chk("dec_sys", "rdata", rd, s_rdata[0]);
    xfer(32'h1000_0000, 0, 0, 4'h0, 0, 0, rd);
    chk("dec_uart", "sel", {28'h0, last_sel}, 32'h2);
    chk("dec_uart", "rdata", rd, s_rdata[1]);
    xfer(32'h1000_2004, 0, 0, 4'h0, 0, 0, rd);
    chk("dec_timer", "sel", {28'h0, last_sel}, 32'h4);
    chk("dec_timer", "rdata", rd, s_rdata[2]);
    xfer(32'h8000_0010, 0, 0, 4'h0, 3, 0, rd);
    chk("sram_wait", "pready", {31'h0, last_rdy}, 32'h1);

    // unmapped access raises the bus-error source
    xfer(32'h1000_1000, 1, 32'h3, 4'hF, 0, 0, rd);
    xfer(32'h2000_0000, 0, 0, 4'h0, 0, 0, rd);
    chk("unmapped", "pready", {31'h0, last_rdy}, 32'h1);
    chk("unmapped", "perr", {31'h0, last_err}, 32'h1);
    chk("unmapped", "prdata", rd, 32'h0);
    xfer(32'h1000_1000, 0, 0, 4'h0, 0, 0, rd);
    chk("unmapped", "pending", rd, 32'h2);

    // timer interrupt path
    xfer(32'h1000_1004, 1, 32'h8000_0001, 4'hF, 0, 0, rd);
    timer_irq = 1'b1;
    step("tpulse");
    timer_irq = 1'b0;
    chk("tpulse", "cpu_irq", {31'h0, cpu_irq}, 32'h1);
    xfer(32'h1000_1008, 0, 0, 4'h0, 0, 0, rd);
    chk("cause", "rdata", rd, 32'h0);
    xfer(32'h1000_1000, 1, 32'h1, 4'hF, 0, 0, rd);
    chk("w1c", "cpu_irq", {31'h0, cpu_irq}, 32'h0);

    // set wins over write-1-clear
    timer_irq = 1'b1;
    xfer(32'h1000_1000, 1, 32'h1, 4'hF, 0, 0, rd);
    timer_irq = 1'b0;
    xfer(32'h1000_1000, 0, 0, 4'h0, 0, 0, rd);
    chk("set_wins", "pending", rd, 32'h3);

    // byte strobes
    xfer(32'h1000_1004, 1, 32'h0, 4'hF, 0, 0, rd);
    xfer(32'h1000_1004, 1, 32'hFFFF_FFFF, 4'h1, 0, 0, rd);
    xfer(32'h1000_1004, 0, 0, 4'h0, 0, 0, rd);
    chk("strobe", "enable", rd, 32'h3);

    // bad intc offsets
    xfer(32'h1000_1000, 1, 32'h3, 4'hF, 0, 0, rd);
    xfer(32'h1000_1010, 0, 0, 4'h0, 0, 0, rd);
    chk("off10", "perr", {31'h0, last_err}, 32'h1);
    xfer(32'h1000_1000, 0, 0, 4'h0, 0, 0, rd);
    chk("off10", "pending", rd, 32'h2);
    xfer(32'h1000_1000, 1, 32'h3, 4'hF, 0, 0, rd);
    xfer(32'h1000_1006, 1, 32'h3, 4'hF, 0, 0, rd);
    chk("off6", "perr", {31'h0, last_err}, 32'h1);
    xfer(32'h1000_1000, 0, 0, 4'h0, 0, 0, rd);
    chk("off6", "pending", rd, 32'h2);

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 6);
      case (sel)
        0: a = {16'h0000, 16'($urandom)};
        1: a = 32'h1000_0000 | {20'h0, 12'($urandom)};
        2, 6: a = 32'h1000_1000 + offs[$urandom_range(0, 8)];
        3: a = 32'h1000_2000 | {20'h0, 12'($urandom)};
        4: a = 32'h8000_0000 | {1'b0, 31'($urandom)};
        default: a = umap[$urandom_range(0, 3)];
      endcase
      for (int i = 0; i < 4; i++) s_rdata[i] = $urandom;
      timer_irq = ($urandom_range(0, 3) == 0);
      rts = ($urandom_range(0, 39) == 0);
      w = (region(a) < 4) ? $urandom_range(0, 2) : 0;
      xfer(a, 1'($urandom), $urandom, 4'($urandom), w, ($urandom_range(0, 7) == 0), rd);
      if ($urandom_range(0, 3) == 0) step("idle");
    end
    rts = 1'b0; timer_irq = 1'b0;
    step("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_intc_hub.md
# apb_intc_hub

Combined APB interconnect and interrupt controller between the single CPU APB master and the SoC peripherals. Decodes every master transfer to one of four external slaves (system ROM/RAM, console UART, timer, main SRAM) or the internal interrupt-controller register window. Returns decode errors for unmapped addresses. Collects the timer interrupt and bus-error events into a single level interrupt line to the CPU.

## Interface
- Parameters:
  - ADDR_WIDTH, 32: APB address width.
  - DATA_WIDTH, 32: APB data width.
- Clocking and reset: one clock; reset is synchronous and active-high.
- Ports:
  - clk  in  1  system clock; all state updates on the rising edge.
  - rts  in  1  synchronous active-high reset.
  - paddr  in  ADDR_WIDTH  master address.
  - pwdata  in  DATA_WIDTH  master write data.
  - pwrite  in  1  1 = write.
  - pstb  in  4  byte write strobes; bit n covers pwdata[8n+7:8n].
  - psel  in  1  master select (setup and access phases).
  - penable  in  1  access phase.
  - prdata  out  DATA_WIDTH  read data returned to the master.
  - pready  out  1  transfer complete.
  - perr  out  1  transfer error, valid with pready.
  - S_sel / S_enable  out  1 each  routed psel/penable, for S in {system, uart, timer, sram}.
  - S_rdata  in  DATA_WIDTH  slave read data.
  - S_ready / S_err  in  1 each  slave completion and error.
  - timer_irq  in  1  level interrupt from the timer.
  - cpu_irq  out  1  interrupt request to the CPU.

## Operation
- Address map. Address checks are evaluated in this order; the first hit wins.
  - sram: paddr[31]=1, i.e. 0x8000_0000–0xFFFF_FFFF.
  - system: 0x0000_0000–0x0000_FFFF.
  - uart: 0x1000_0000–0x1000_0FFF.
  - intc: 0x1000_1000–0x1000_1FFF (internal).
  - timer: 0x1000_2000–0x1000_2FFF.
  - Everything else is unmapped.
- Routing is purely combinational.
  - S_sel = psel & hit_S; S_enable = penable & hit_S.
  - prdata, pready and perr are muxed from the hit slave.
  - When no slave is hit, prdata = 0.
- Unmapped access: the fabric answers itself with pready=1 and perr=1 when psel&penable; prdata=0.
- With psel=0: pready=0, perr=0, and all S_sel/S_enable are 0.
- intc registers. Offsets are from 0x1000_1000; the word address is paddr[11:2].
  - 0x0 PENDING, bits[1:0]. Bit0 is the timer source, bit1 is the bus-error source. Sticky. Writing 1 clears a bit (honouring pstb[0]); writing 0 has no effect.
  - 0x4 ENABLE, bits[1:0] are per-source enables and bit31 is the global enable. Read/write with byte strobes. Bits [30:2] read as 0 and ignore writes.
  - 0x8 CAUSE, read-only. Holds the index of the lowest-numbered pending&enabled source, or 0xFFFF_FFFF if none. Writes are ignored without error.
  - Any other offset, or paddr[1:0]≠0, gives perr=1 with no state change.
- Pending set rules:
  - PENDING[0] sets in every cycle where timer_irq=1.
  - PENDING[1] sets in every cycle where psel&penable&pready&perr=1. This covers errors from any slave, including the fabric itself and intc.
  - If a set and a write-1-clear hit the same bit in the same cycle, the set wins.
- Interrupt output: cpu_irq = ENABLE[31] & |(PENDING[1:0] & ENABLE[1:0]). It is combinational from the registers.
- While rts=1:
  - All intc registers are forced to 0 and all source sets are suppressed.
  - intc reads return 0 and writes are ignored.
  - Fabric routing continues to operate.

## Timing
- Reset values: PENDING=0, ENABLE=0, cpu_irq=0. All other outputs are combinational and have no stored reset value.
- External slaves: latency is set by the slave. Wait states pass through unchanged (pready follows S_ready).
- intc and unmapped accesses have zero wait states: pready=1 in the first access-phase cycle.
- intc write commits on the rising edge that ends the access phase (psel&penable&pwrite).
- intc read data is combinational from the current register values during the access phase.
- Interrupt latency:
  - A timer_irq high on edge N sets PENDING[0] at N, and cpu_irq rises in the following cycle.
  - A bus error completing at edge N likewise raises cpu_irq after edge N.
- A setup phase alone (psel=1, penable=0) never changes state and never reports an error.

## Test plan
- Reset:
  - Hold rts for 2 cycles while timer_irq=1. Expected: PENDING=0, ENABLE=0, cpu_irq=0 throughout.
  - After release, read 0x1000_1000 twice. Expected: first read returns 0 (reset state); the second returns 1, because timer_irq=1 sets PENDING[0] from the first post-reset cycle.
- Decode:
  - Reads at 0x8000_0010, 0x0000_0004, 0x1000_0000 and 0x1000_2004. Expected: exactly one of sram_sel, system_sel, uart_sel, timer_sel asserts respectively, and prdata equals that slave's S_rdata.
  - Slave wait states: sram holds ready=0 for 3 cycles. Expected: pready stays 0 for those 3 cycles.
- Unmapped access: read 0x2000_0000. Expected: pready=1, perr=1, prdata=0 in the first access cycle. Then PENDING reads 0x2.
- Timer interrupt:
  - Write ENABLE=0x8000_0001, then pulse timer_irq for 1 cycle. Expected: cpu_irq=1 the next cycle, and CAUSE reads 0.
  - Write PENDING=0x1. Expected: cpu_irq=0 the next cycle.
- Simultaneous set and clear: timer_irq=1 in the same cycle as a write PENDING=0x1. Expected: PENDING[0] stays 1.
- Strobes and bad offset:
  - Write ENABLE=0xFFFF_FFFF with pstb=0x1. Expected: ENABLE reads 0x0000_0003.
  - Access offset 0x10 or 0x6 in the intc window. Expected: perr=1, and the bus-error pending bit sets.
